// File: rtl/spmmio_arbiter.sv
// spmmio_arbiter: two-master round-robin bus arbiter with slave-ack watchdog.
// Rev 1.0
`default_nettype none

module spmmio_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [23:0] m0_adr_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic [23:0] m1_adr_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic [23:0] s_adr_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  input  logic        to_clr,
  output logic        to_flag,
  output logic [23:0] to_adr,
  output logic        to_mst
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
  localparam bit            WD_EN    = (TIMEOUT != 0);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          last_served;
  logic          last_served_nxt;
  logic [CW-1:0] wd_cnt;
  logic          err_cycle;
  logic          wd_fire;
  logic          slv_stb;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
    end
  end

  // Next-state: a tie in IDLE goes to the master that was not served last
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_nxt = last_served ? ST_OWN0 : ST_OWN1;
        else if (m0_cyc_i)
          state_nxt = ST_OWN0;
        else if (m1_cyc_i)
          state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          state_nxt       = m1_cyc_i ? ST_OWN1 : ST_IDLE;
          last_served_nxt = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          state_nxt       = m0_cyc_i ? ST_OWN0 : ST_IDLE;
          last_served_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output mux: slave side follows the owner, returns go only to the owner
  always_comb begin
    s_adr_o  = 24'd0;
    s_cyc_o  = 1'b0;
    slv_stb  = 1'b0;
    s_sel_o  = 4'd0;
    s_we_o   = 1'b0;
    s_dat_o  = 32'd0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = 32'd0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = 32'd0;
    case (state)
      ST_OWN0: begin
        s_adr_o  = m0_adr_i;
        s_cyc_o  = m0_cyc_i;
        slv_stb  = m0_cyc_i & m0_stb_i & ~err_cycle;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i & slv_stb;
        m0_err_o = err_cycle;
        m0_dat_o = s_dat_i;
      end
      ST_OWN1: begin
        s_adr_o  = m1_adr_i;
        s_cyc_o  = m1_cyc_i;
        slv_stb  = m1_cyc_i & m1_stb_i & ~err_cycle;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i & slv_stb;
        m1_err_o = err_cycle;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

  assign s_stb_o = slv_stb;

  // An ack arriving on the limit cycle suppresses the error
  assign wd_fire = WD_EN && slv_stb && !s_ack_i && (wd_cnt == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      err_cycle <= 1'b0;
    end else begin
      err_cycle <= wd_fire;
      if (!WD_EN || !slv_stb || s_ack_i || wd_fire || (state_nxt != state))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // A new error outranks a simultaneous clear and recaptures the address
  always_ff @(posedge clk) begin
    if (reset) begin
      to_flag <= 1'b0;
      to_adr  <= 24'd0;
      to_mst  <= 1'b0;
    end else if (err_cycle && (!to_flag || to_clr)) begin
      to_flag <= 1'b1;
      to_adr  <= s_adr_o;
      to_mst  <= (state == ST_OWN1);
    end else if (to_clr) begin
      to_flag <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spmmio_arbiter.sv
// Directed bench for spmmio_arbiter, built with a 4-cycle watchdog.
`default_nettype none

module tb_spmmio_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] m0_adr_i, m1_adr_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_i, m1_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic [23:0] s_adr_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic        to_clr;
  logic        to_flag;
  logic [23:0] to_adr;
  logic        to_mst;

  int vectors    = 0;
  int miscompares = 0;

  spmmio_arbiter #(.TIMEOUT(4), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .to_clr(to_clr), .to_flag(to_flag), .to_adr(to_adr), .to_mst(to_mst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs then change away from the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_adr_i = '0; m0_cyc_i = 0; m0_stb_i = 0; m0_sel_i = 4'hF; m0_we_i = 0; m0_dat_i = 32'hA0A0_0000;
    m1_adr_i = '0; m1_cyc_i = 0; m1_stb_i = 0; m1_sel_i = 4'h3; m1_we_i = 0; m1_dat_i = 32'hB1B1_0000;
    s_ack_i = 0; s_dat_i = 32'hDEAD_BEEF; to_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_m0_dat", m0_dat_o, 32'd0);
    chk("rst_m1_ack", 32'(m1_ack_o), 32'd0);
    chk("rst_to_flag", 32'(to_flag), 32'd0);
    chk("rst_to_adr", 32'(to_adr), 32'd0);
    chk("rst_to_mst", 32'(to_mst), 32'd0);

    // Single zero-wait read by m0
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000010; s_ack_i = 1; s_dat_i = 32'h12345678;
    #1;
    chk("t1_req_stb", 32'(s_stb_o), 32'd0);
    chk("t1_req_ack", 32'(m0_ack_o), 32'd0);
    step(); #1;
    chk("t1_stb", 32'(s_stb_o), 32'd1);
    chk("t1_adr", 32'(s_adr_o), 32'h10);
    chk("t1_ack", 32'(m0_ack_o), 32'd1);
    chk("t1_dat", m0_dat_o, 32'h12345678);
    chk("t1_m1_dat", m1_dat_o, 32'd0);
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    step(); step();

    // Tie out of reset, direct handoff, round-robin on repeated ties
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000200; s_ack_i = 1;
    #1;
    chk("t2_idle_cyc", 32'(s_cyc_o), 32'd0);
    step(); #1;
    chk("t2_g0_adr", 32'(s_adr_o), 32'h100);
    chk("t2_g0_ack0", 32'(m0_ack_o), 32'd1);
    chk("t2_g0_ack1", 32'(m1_ack_o), 32'd0);
    m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("t2_drop_cyc", 32'(s_cyc_o), 32'd0);
    chk("t2_drop_ack1", 32'(m1_ack_o), 32'd0);
    step(); #1;
    chk("t2_hand_adr", 32'(s_adr_o), 32'h200);
    chk("t2_hand_ack1", 32'(m1_ack_o), 32'd1);
    chk("t2_hand_ack0", 32'(m0_ack_o), 32'd0);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step(); #1;
    chk("t2_tie2_adr", 32'(s_adr_o), 32'h100);
    chk("t2_tie2_ack0", 32'(m0_ack_o), 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step(); #1;
    chk("t2_tie3_adr", 32'(s_adr_o), 32'h200);
    chk("t2_tie3_ack1", 32'(m1_ack_o), 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step(); step();

    // m1 holds the bus across three strobes while m0 waits
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000300;
    step();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000500;
    for (int i = 0; i < 3; i++) begin
      m1_adr_i = 24'h000300 + 24'(4 * i);
      #1;
      chk("t3_m1_ack", 32'(m1_ack_o), 32'd1);
      chk("t3_m0_ack", 32'(m0_ack_o), 32'd0);
      chk("t3_adr", 32'(s_adr_o), 32'h300 + 32'(4 * i));
      step();
    end
    m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    chk("t3_rel_m0_ack", 32'(m0_ack_o), 32'd0);
    step(); #1;
    chk("t3_m0_adr", 32'(s_adr_o), 32'h500);
    chk("t3_m0_ack_g", 32'(m0_ack_o), 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    step(); step();

    // Ack on the limit cycle beats the watchdog
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000040;
    step(); #1;
    chk("t5_stb", 32'(s_stb_o), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(); #1;
      chk("t5_wait_ack", 32'(m0_ack_o), 32'd0);
    end
    step();
    s_ack_i = 1;
    #1;
    chk("t5_lim_ack", 32'(m0_ack_o), 32'd1);
    m0_stb_i = 0; s_ack_i = 0;
    step(); #1;
    chk("t5_no_err", 32'(m0_err_o), 32'd0);
    step(); #1;
    chk("t5_flag", 32'(to_flag), 32'd0);
    m0_cyc_i = 0;
    step(); step();

    // m1 write never acked: error pulse five cycles after the strobe
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 24'h030100;
    step(); #1;
    chk("t4_stb", 32'(s_stb_o), 32'd1);
    chk("t4_we", 32'(s_we_o), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      chk("t4_pre_err", 32'(m1_err_o), 32'd0);
      chk("t4_pre_stb", 32'(s_stb_o), 32'd1);
    end
    step();
    s_ack_i = 1;
    #1;
    chk("t4_err", 32'(m1_err_o), 32'd1);
    chk("t4_err_stb", 32'(s_stb_o), 32'd0);
    chk("t4_err_ack", 32'(m1_ack_o), 32'd0);
    m1_stb_i = 0; s_ack_i = 0;
    step(); #1;
    chk("t4_err_off", 32'(m1_err_o), 32'd0);
    chk("t4_flag", 32'(to_flag), 32'd1);
    chk("t4_adr", 32'(to_adr), 32'h030100);
    chk("t4_mst", 32'(to_mst), 32'd1);
    m1_cyc_i = 0; m1_we_i = 0;
    step(); step();

    // Second timeout coinciding with to_clr recaptures
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000ABC;
    for (int i = 0; i <= 4; i++) step();
    step();
    to_clr = 1;
    #1;
    chk("t6_err", 32'(m0_err_o), 32'd1);
    m0_stb_i = 0;
    step();
    to_clr = 0;
    #1;
    chk("t6_flag", 32'(to_flag), 32'd1);
    chk("t6_adr", 32'(to_adr), 32'h000ABC);
    chk("t6_mst", 32'(to_mst), 32'd0);
    m0_cyc_i = 0;
    step();
    to_clr = 1;
    step();
    to_clr = 0;
    #1;
    chk("t6_clr_flag", 32'(to_flag), 32'd0);
    chk("t6_clr_adr", 32'(to_adr), 32'h000ABC);
    step();

    // Reset in the middle of an m1 burst
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h123456; s_dat_i = 32'hCAFE_F00D;
    step(); #1;
    chk("t7_pre_cyc", 32'(s_cyc_o), 32'd1);
    reset = 1;
    step(); #1;
    chk("t7_cyc", 32'(s_cyc_o), 32'd0);
    chk("t7_stb", 32'(s_stb_o), 32'd0);
    chk("t7_adr", 32'(s_adr_o), 32'd0);
    chk("t7_dat", m1_dat_o, 32'd0);
    chk("t7_ack", 32'(m1_ack_o), 32'd0);
    reset = 0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
